vend_sequencer: RTL and testbench

- Controller that sequences the vending FSM's state registers from queued coin insertions.
- Edge-detects debounced coin switches and buffers coins in a small FIFO.
- Presents one encoded coin per transaction and issues a single-cycle step strobe to the state registers.
- Holds the dispense/refund display for a fixed time, then clears the FSM. Replaces manual push-button clocking of the FSM.

---
 rtl/vend_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_vend_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer.sv
// vend_sequencer
//   Drives the vending FSM's state registers from queued coin insertions,
//   replacing manual push-button clocking. Rising edges on the debounced coin
//   switches are buffered in a small FIFO; each coin becomes one transaction
//   that presents an encoded coin, pulses `step` once, lets the FSM settle and
//   then checks `item`. A dispense (or a requested refund) is displayed for
//   HOLD_CYCLES cycles, after which the FSM registers are cleared.
//
// Ports
//   CLK50M       in   board clock (50 MHz)
//   RSTb         in   asynchronous active-low reset
//   coin_req     in   [3:0] debounced coin switches, rising edge = one coin
//   cancel       in   debounced refund button, rising edge = refund request
//   item         in   FSM output: item dispensed in the current state
//   coin_code    out  [1:0] encoded coin for the FSM next-state logic
//   step         out  one-cycle advance strobe for the FSM state registers
//   fsm_rstb     out  active-low clear for the FSM state registers
//   busy         out  controller not idle
//   hold_active  out  dispense display hold in progress
//   refund       out  refund display hold in progress
//   coin_drop    out  sticky: a coin edge was lost
//   fifo_cnt     out  coin FIFO occupancy
module vend_sequencer #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          CLK50M,
  input  logic                          RSTb,
  input  logic [3:0]                    coin_req,
  input  logic                          cancel,
  input  logic                          item,
  output logic [1:0]                    coin_code,
  output logic                          step,
  output logic                          fsm_rstb,
  output logic                          busy,
  output logic                          hold_active,
  output logic                          refund,
  output logic                          coin_drop,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] HOLD_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STEP,
    S_SETTLE,
    S_CHECK,
    S_HOLD,
    S_REFUND,
    S_CLEAR
  } state_t;

  // Highest-numbered coin wins when several edges coincide.
  function automatic logic [1:0] coin_encode(input logic [3:0] e);
    logic [1:0] c;
    if (e[3])      c = 2'd3;
    else if (e[2]) c = 2'd2;
    else if (e[1]) c = 2'd1;
    else           c = 2'd0;
    return c;
  endfunction

  function automatic logic multi_hot(input logic [3:0] e);
    return (e & (e - 4'd1)) != 4'd0;
  endfunction

  state_t            state, state_nxt;
  logic [3:0]        coin_prev_p0;
  logic              cancel_prev_p0;
  logic              cancel_pend;
  logic              fsm_arm;
  logic              refund_clr;
  logic [CW-1:0]     hold_cnt;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [1:0]        fifo_mem [FIFO_DEPTH];

  logic [3:0]        coin_edge;
  logic              discard;
  logic              push_req;
  logic [1:0]        push_code;
  logic              fifo_full;
  logic              pop;
  logic              bypass;
  logic              push_ok;
  logic              do_wr, do_rd;
  logic              flush;
  logic              cnt_load;
  logic              cancel_clr;

  // ---- stage p0: edge detect against previous switch sample ----
  assign coin_edge = coin_req & ~coin_prev_p0;
  // Coins offered during a refund (and the clear that follows it) are ignored
  // silently: the customer is getting everything back anyway.
  assign discard   = (state == S_REFUND) || ((state == S_CLEAR) && refund_clr);
  assign push_req  = (|coin_edge) && !discard;
  assign push_code = coin_encode(coin_edge);
  assign fifo_full = (fifo_cnt == CNT_FULL);
  // An empty FIFO hands the incoming coin straight to coin_code so an idle
  // controller enters SETUP on the very next cycle.
  assign bypass    = pop && (fifo_cnt == '0);
  assign push_ok   = push_req && (!fifo_full || pop);
  assign do_wr     = push_ok && !bypass;
  assign do_rd     = pop && !bypass;
  assign flush     = (state == S_CLEAR) && refund_clr;

  always_ff @(posedge CLK50M or negedge RSTb) begin
    if (!RSTb) begin
      coin_prev_p0   <= 4'b1111;
      cancel_prev_p0 <= 1'b1;
    end else begin
      coin_prev_p0   <= coin_req;
      cancel_prev_p0 <= cancel;
    end
  end

  // ---- FSM state register ----
  always_ff @(posedge CLK50M or negedge RSTb) begin
    if (!RSTb) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ---- FSM next state and outputs ----
  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    cnt_load    = 1'b0;
    cancel_clr  = 1'b0;
    step        = 1'b0;
    busy        = 1'b1;
    hold_active = 1'b0;
    refund      = 1'b0;
    fsm_rstb    = fsm_arm;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (cancel_pend) begin
          state_nxt  = S_REFUND;
          cnt_load   = 1'b1;
          cancel_clr = 1'b1;
        end else if ((fifo_cnt != '0) || push_req) begin
          state_nxt = S_SETUP;
          pop       = 1'b1;
        end
      end
      S_SETUP:  state_nxt = S_STEP;
      S_STEP: begin
        step      = 1'b1;
        state_nxt = S_SETTLE;
      end
      S_SETTLE: state_nxt = S_CHECK;
      S_CHECK: begin
        if (item) begin
          state_nxt = S_HOLD;
          cnt_load  = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        hold_active = 1'b1;
        if (hold_cnt == HOLD_ONE) state_nxt = S_CLEAR;
      end
      S_REFUND: begin
        refund = 1'b1;
        if (hold_cnt == HOLD_ONE) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        fsm_rstb  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- control registers ----
  always_ff @(posedge CLK50M or negedge RSTb) begin
    if (!RSTb) begin
      fsm_arm     <= 1'b0;
      refund_clr  <= 1'b0;
      cancel_pend <= 1'b0;
      coin_drop   <= 1'b0;
      hold_cnt    <= '0;
      coin_code   <= 2'd0;
    end else begin
      fsm_arm    <= 1'b1;
      // REFUND only ever exits to CLEAR, so this marks a post-refund CLEAR.
      refund_clr <= (state == S_REFUND);
      // Clearing on REFUND entry wins over a coincident edge.
      if (cancel_clr)
        cancel_pend <= 1'b0;
      else if (cancel && !cancel_prev_p0)
        cancel_pend <= 1'b1;
      if ((push_req && multi_hot(coin_edge)) || (push_req && fifo_full && !pop))
        coin_drop <= 1'b1;
      if (cnt_load)
        hold_cnt <= HOLD_LOAD;
      else if ((state == S_HOLD) || (state == S_REFUND))
        hold_cnt <= hold_cnt - HOLD_ONE;
      if (pop)
        coin_code <= bypass ? push_code : fifo_mem[rd_ptr];
    end
  end

  // ---- coin FIFO ----
  always_ff @(posedge CLK50M or negedge RSTb) begin
    if (!RSTb) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      if (do_wr && !do_rd)
        fifo_cnt <= fifo_cnt + CNT_ONE;
      else if (!do_wr && do_rd)
        fifo_cnt <= fifo_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge CLK50M) begin
    if (do_wr) fifo_mem[wr_ptr] <= push_code;
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer with HOLD_CYCLES=4, FIFO_DEPTH=4.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same
// point, so each tick() lands in the next controller cycle. Every step pulse
// pops the scoreboard queue and compares coin_code.
module tb_vend_sequencer;

  localparam int HOLD  = 4;
  localparam int DEPTH = 4;

  logic       CLK50M = 1'b0;
  logic       RSTb   = 1'b0;
  logic [3:0] coin_req = 4'd0;
  logic       cancel = 1'b0;
  logic       item   = 1'b0;
  logic [1:0] coin_code;
  logic       step, fsm_rstb, busy, hold_active, refund, coin_drop;
  logic [2:0] fifo_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_steps  = 0;
  logic prev_step = 1'b0;
  logic [1:0] exp_q[$];

  typedef struct {
    logic [3:0] req;
    logic [1:0] code;
    logic       drop;
  } vec_t;

  vec_t vecs[5];

  vend_sequencer #(.HOLD_CYCLES(HOLD), .FIFO_DEPTH(DEPTH)) dut (
    .CLK50M(CLK50M), .RSTb(RSTb), .coin_req(coin_req), .cancel(cancel),
    .item(item), .coin_code(coin_code), .step(step), .fsm_rstb(fsm_rstb),
    .busy(busy), .hold_active(hold_active), .refund(refund),
    .coin_drop(coin_drop), .fifo_cnt(fifo_cnt)
  );

  always #10 CLK50M = ~CLK50M;

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [1:0] e;
    @(posedge CLK50M);
    #1;
    if (step) begin
      n_steps++;
      check("step_back_to_back", prev_step, 0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_step: got code %0d expected no step", coin_code);
      end else begin
        e = exp_q.pop_front();
        check("sb_code", coin_code, e);
      end
    end
    prev_step = step;
  endtask

  task automatic wait_idle(input int max_cycles);
    int k;
    k = 0;
    while (busy && k < max_cycles) begin
      tick();
      k++;
    end
    check("idle_timeout", busy, 0);
  endtask

  initial begin
    int steps_before;
    int k;

    vecs[0] = '{req: 4'b0010, code: 2'd1, drop: 1'b0};
    vecs[1] = '{req: 4'b0001, code: 2'd0, drop: 1'b0};
    vecs[2] = '{req: 4'b0100, code: 2'd2, drop: 1'b0};
    vecs[3] = '{req: 4'b1000, code: 2'd3, drop: 1'b0};
    vecs[4] = '{req: 4'b1001, code: 2'd3, drop: 1'b1};

    // Reset state
    #3;
    check("rst_step", step, 0);
    check("rst_code", coin_code, 0);
    check("rst_fsm_rstb", fsm_rstb, 0);
    check("rst_busy", busy, 0);
    check("rst_hold", hold_active, 0);
    check("rst_refund", refund, 0);
    check("rst_drop", coin_drop, 0);
    check("rst_cnt", fifo_cnt, 0);
    tick(); tick();
    RSTb = 1'b1;
    check("rel_fsm_rstb_pre", fsm_rstb, 0);
    tick();
    check("rel_fsm_rstb_post", fsm_rstb, 1);
    repeat (3) tick();

    // Single-coin transactions, item stays 0
    for (int i = 0; i < 5; i++) begin
      coin_req = vecs[i].req;
      exp_q.push_back(vecs[i].code);
      tick();
      coin_req = 4'd0;
      check("tv_setup_busy", busy, 1);
      check("tv_setup_code", coin_code, vecs[i].code);
      check("tv_setup_step", step, 0);
      check("tv_setup_cnt", fifo_cnt, 0);
      tick();
      check("tv_step", step, 1);
      check("tv_step_busy", busy, 1);
      tick();
      check("tv_settle_step", step, 0);
      check("tv_settle_busy", busy, 1);
      tick();
      check("tv_check_busy", busy, 1);
      check("tv_check_hold", hold_active, 0);
      tick();
      check("tv_idle_busy", busy, 0);
      check("tv_idle_code_held", coin_code, vecs[i].code);
      check("tv_idle_drop", coin_drop, vecs[i].drop);
      check("tv_idle_cnt", fifo_cnt, 0);
      repeat (2) tick();
    end
    check("tv_steps", n_steps, 5);

    // Reset pulsed during HOLD cycle 2 with a coin queued
    coin_req = 4'b0100;
    exp_q.push_back(2'd2);
    tick();                      // SETUP
    coin_req = 4'd0;
    tick();                      // STEP
    item = 1'b1;
    tick();                      // SETTLE
    tick();                      // CHECK
    tick();                      // HOLD 1
    check("rh_hold1", hold_active, 1);
    coin_req = 4'b0010;
    tick();                      // HOLD 2
    check("rh_hold2", hold_active, 1);
    check("rh_cnt_before", fifo_cnt, 1);
    #2;
    RSTb = 1'b0;
    coin_req = 4'b0101;
    item = 1'b0;
    #1;
    check("rh_step", step, 0);
    check("rh_code", coin_code, 0);
    check("rh_fsm_rstb", fsm_rstb, 0);
    check("rh_busy", busy, 0);
    check("rh_hold", hold_active, 0);
    check("rh_refund", refund, 0);
    check("rh_drop", coin_drop, 0);
    check("rh_cnt", fifo_cnt, 0);
    tick();
    check("rh_in_reset_fsm_rstb", fsm_rstb, 0);
    RSTb = 1'b1;
    check("rh_rel_pre", fsm_rstb, 0);
    tick();
    check("rh_rel_post", fsm_rstb, 1);
    repeat (3) tick();
    check("rh_held_sw_busy", busy, 0);
    check("rh_held_sw_cnt", fifo_cnt, 0);
    coin_req = 4'd0;
    repeat (2) tick();

    // Dispense: hold for exactly HOLD cycles, one clear cycle, then IDLE
    coin_req = 4'b0100;
    exp_q.push_back(2'd2);
    tick();
    coin_req = 4'd0;
    check("dh_setup_code", coin_code, 2);
    tick();
    check("dh_step", step, 1);
    item = 1'b1;
    tick();
    tick();
    check("dh_check_hold", hold_active, 0);
    for (int h = 0; h < HOLD; h++) begin
      tick();
      check("dh_hold", hold_active, 1);
      check("dh_hold_fsm_rstb", fsm_rstb, 1);
    end
    tick();
    check("dh_clear_hold", hold_active, 0);
    check("dh_clear_fsm_rstb", fsm_rstb, 0);
    check("dh_clear_busy", busy, 1);
    item = 1'b0;
    tick();
    check("dh_idle_busy", busy, 0);
    check("dh_idle_fsm_rstb", fsm_rstb, 1);
    repeat (2) tick();

    // Cancel during a transaction with a second coin queued
    coin_req = 4'b0010;
    exp_q.push_back(2'd1);
    tick();                      // SETUP
    coin_req = 4'b0011;
    tick();                      // STEP, bit0 edge pushed
    check("cn_cnt_queued", fifo_cnt, 1);
    cancel = 1'b1;
    tick();                      // SETTLE
    cancel = 1'b0;
    coin_req = 4'd0;
    tick();                      // CHECK
    tick();                      // IDLE
    check("cn_idle_busy", busy, 0);
    check("cn_idle_refund", refund, 0);
    tick();                      // REFUND 1
    check("cn_refund1", refund, 1);
    check("cn_refund1_cnt", fifo_cnt, 1);
    coin_req = 4'b1000;
    tick();                      // REFUND 2
    check("cn_refund2", refund, 1);
    check("cn_refund_edge_ignored", fifo_cnt, 1);
    check("cn_refund_no_drop", coin_drop, 0);
    coin_req = 4'd0;
    tick();
    check("cn_refund3", refund, 1);
    tick();
    check("cn_refund4", refund, 1);
    tick();                      // CLEAR
    check("cn_clear_refund", refund, 0);
    check("cn_clear_fsm_rstb", fsm_rstb, 0);
    tick();                      // IDLE, flushed
    check("cn_flushed", fifo_cnt, 0);
    check("cn_idle2_busy", busy, 0);
    steps_before = n_steps;
    repeat (8) tick();
    check("cn_no_second_step", n_steps - steps_before, 0);
    check("cn_still_idle", busy, 0);

    // Five edges while held: four queue, the fifth is dropped
    coin_req = 4'b0100;
    exp_q.push_back(2'd2);
    tick();                      // SETUP
    coin_req = 4'd0;
    tick();                      // STEP
    item = 1'b1;
    tick();                      // SETTLE
    tick();                      // CHECK
    coin_req = 4'b1000;
    tick();                      // HOLD 1
    coin_req = 4'b1100;
    tick();
    coin_req = 4'b0110;
    tick();
    coin_req = 4'b0111;
    tick();                      // HOLD 4
    check("ff_hold4", hold_active, 1);
    check("ff_cnt_full", fifo_cnt, 4);
    check("ff_no_drop_yet", coin_drop, 0);
    coin_req = 4'b1111;
    tick();                      // CLEAR
    check("ff_clear_fsm_rstb", fsm_rstb, 0);
    check("ff_cnt_after_drop", fifo_cnt, 4);
    check("ff_drop", coin_drop, 1);
    item = 1'b0;
    coin_req = 4'd0;
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd0);
    steps_before = n_steps;
    k = 0;
    while (((n_steps - steps_before) < 4 || busy) && k < 40) begin
      tick();
      k++;
    end
    check("ff_step_count", n_steps - steps_before, 4);
    wait_idle(10);
    check("ff_cnt_empty", fifo_cnt, 0);
    check("sb_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
